// File: rtl/mem_timed_pkg.sv
// mem_timed_pkg: state encoding and default access times for mem_timed_sram
package mem_timed_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE, ST_RELEASE} mem_timed_state_e;
  localparam int MEM_T_WRITE_DEF = 43;
  localparam int MEM_T_READ_DEF = 35;
endpackage

// File: rtl/mem_timed_array.sv
// mem_timed_array: unreset storage with one sync write port and one registered read port
module mem_timed_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 256,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic              rok_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  always_ff @(posedge clk)
    if (we_i) mem[waddr_i] <= wdata_i;
  // only the read register resets; stored words survive rst
  always_ff @(posedge clk)
    if (rst) rdata_q <= '0;
    else if (re_i) rdata_q <= rok_i ? mem[raddr_i] : '0;
  assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_timed_sram.sv
// mem_timed_sram: SRAM with programmable access times and four-phase sel/ready handshake
// Optional MEM_TIMED_XPROP_EN drives mem_rdata to X whenever it is not valid read data.
module mem_timed_sram
  import mem_timed_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH = 256,
  parameter int T_WRITE = MEM_T_WRITE_DEF,
  parameter int T_READ = MEM_T_READ_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_sel,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_err
);
  localparam int TMAX = T_WRITE > T_READ ? T_WRITE : T_READ;
  localparam int CW = $clog2(TMAX + 1);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  mem_timed_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rd_data;
  logic in_range, hit;
  assign in_range = {1'b0, addr_q} < (ADDR_W + 1)'(DEPTH);
  // an abort (sel low) takes priority over completion on the same edge
  assign hit = state_q == ST_WAIT && mem_sel &&
               cnt_q == (we_q ? CW'(T_WRITE - 1) : CW'(T_READ - 1));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: if (mem_sel) begin
        state_d = ST_WAIT;
        cnt_d = '0;
        we_d = mem_we;
        addr_d = mem_addr;
        wdata_d = mem_wdata;
      end
      ST_WAIT: begin
        state_d = !mem_sel ? ST_RELEASE : hit ? ST_DONE : ST_WAIT;
        cnt_d = hit ? cnt_q : cnt_q + 1'b1;
      end
      ST_DONE: state_d = mem_sel ? ST_DONE : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
    end
  mem_timed_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
    .clk(clk),
    .rst(rst),
    .we_i(hit && we_q && in_range),
    .waddr_i(addr_q[AW-1:0]),
    .wdata_i(wdata_q),
    .re_i(hit && !we_q),
    .rok_i(in_range),
    .raddr_i(addr_q[AW-1:0]),
    .rdata_o(rd_data)
  );
  assign mem_ready = state_q == ST_DONE;
  assign mem_err = mem_ready && !in_range;
`ifdef MEM_TIMED_XPROP_EN
  assign mem_rdata = (mem_ready && !we_q) ? rd_data : 'x;
`else
  assign mem_rdata = rd_data;
`endif
endmodule

// File: tb/tb_mem_timed_sram.sv
// tb_mem_timed_sram: directed checks of timing, abort, range error and reset behaviour
module tb_mem_timed_sram;
  logic clk = 1'b0;
  logic rst, mem_sel, mem_we, mem_ready, mem_err;
  logic [7:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  int n_chk = 0;
  int n_pass = 0;
  int lat;
  always #5 clk = ~clk;
  mem_timed_sram #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .T_WRITE(43), .T_READ(35)) dut (
    .clk(clk), .rst(rst), .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_err(mem_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  // lat = edge number at which mem_ready is first seen, -1 if never within 100 edges
  task automatic do_access(input logic we, input logic [7:0] a, input logic [15:0] d,
                           input int abort_at, input logic chg, output int l);
    mem_we = we;
    mem_addr = a;
    mem_wdata = d;
    mem_sel = 1'b1;
    @(posedge clk);
    #1;
    if (chg) begin
      mem_addr = 8'h06;
      mem_we = ~we;
      mem_wdata = 16'hFFFF;
    end
    l = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (mem_ready && l < 0) l = n;
      if (n == abort_at) mem_sel = 1'b0;
      if (l >= 0 && abort_at == 0) break;
    end
  endtask
  task automatic release_sel(input string tag);
    mem_sel = 1'b0;
    @(posedge clk);
    #1;
    chk(tag, {31'd0, mem_ready}, 32'd0);
  endtask
  initial begin
    rst = 1'b1;
    mem_sel = 1'b0;
    mem_we = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst_err", {31'd0, mem_err}, 32'd0);
    chk("rst_rdata", {16'd0, mem_rdata}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("idle_ready", {31'd0, mem_ready}, 32'd0);
    chk("idle_rdata", {16'd0, mem_rdata}, 32'd0);
    do_access(1'b1, 8'h05, 16'hA5A5, 0, 1'b0, lat);
    chk("wr05_lat", lat, 43);
    chk("wr05_err", {31'd0, mem_err}, 32'd0);
    chk("wr05_rdata_hold", {16'd0, mem_rdata}, 32'd0);
    release_sel("wr05_fall");
    do_access(1'b0, 8'h05, 16'h0000, 0, 1'b0, lat);
    chk("rd05_lat", lat, 35);
    chk("rd05_data", {16'd0, mem_rdata}, 32'h0000A5A5);
    chk("rd05_err", {31'd0, mem_err}, 32'd0);
    release_sel("rd05_fall");
    chk("rd05_rdata_after", {16'd0, mem_rdata}, 32'h0000A5A5);
    do_access(1'b1, 8'h05, 16'h1234, 20, 1'b0, lat);
    chk("abort_noready", lat, 32'hFFFFFFFF);
    do_access(1'b0, 8'h05, 16'h0000, 0, 1'b0, lat);
    chk("rd_abort_lat", lat, 35);
    chk("rd_abort_data", {16'd0, mem_rdata}, 32'h0000A5A5);
    release_sel("rd_abort_fall");
    do_access(1'b1, 8'hF0, 16'hBEEF, 0, 1'b0, lat);
    chk("wrF0_lat", lat, 43);
    chk("wrF0_err", {31'd0, mem_err}, 32'd1);
    release_sel("wrF0_fall");
    do_access(1'b0, 8'hF0, 16'h0000, 0, 1'b0, lat);
    chk("rdF0_lat", lat, 35);
    chk("rdF0_err", {31'd0, mem_err}, 32'd1);
    chk("rdF0_data", {16'd0, mem_rdata}, 32'd0);
    release_sel("rdF0_fall");
    do_access(1'b1, 8'hC7, 16'h1111, 0, 1'b0, lat);
    chk("wrC7_err", {31'd0, mem_err}, 32'd0);
    release_sel("wrC7_fall");
    do_access(1'b1, 8'hC8, 16'h2222, 0, 1'b0, lat);
    chk("wrC8_err", {31'd0, mem_err}, 32'd1);
    release_sel("wrC8_fall");
    do_access(1'b0, 8'hC7, 16'h0000, 0, 1'b0, lat);
    chk("rdC7_data", {16'd0, mem_rdata}, 32'h00001111);
    chk("rdC7_err", {31'd0, mem_err}, 32'd0);
    release_sel("rdC7_fall");
    do_access(1'b1, 8'h06, 16'h5A5A, 0, 1'b0, lat);
    release_sel("wr06_fall");
    do_access(1'b0, 8'h05, 16'h0000, 0, 1'b1, lat);
    chk("chg_lat", lat, 35);
    chk("chg_data", {16'd0, mem_rdata}, 32'h0000A5A5);
    release_sel("chg_fall");
    do_access(1'b1, 8'h07, 16'h7777, 0, 1'b0, lat);
    release_sel("wr07_fall");
    mem_we = 1'b1;
    mem_addr = 8'h07;
    mem_wdata = 16'h8888;
    mem_sel = 1'b1;
    repeat (31) @(posedge clk);
    #1;
    rst = 1'b1;
    mem_sel = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_ready", {31'd0, mem_ready}, 32'd0);
    chk("midrst_err", {31'd0, mem_err}, 32'd0);
    chk("midrst_rdata", {16'd0, mem_rdata}, 32'd0);
    rst = 1'b0;
    do_access(1'b0, 8'h07, 16'h0000, 0, 1'b0, lat);
    chk("rd07_lat", lat, 35);
    chk("rd07_data", {16'd0, mem_rdata}, 32'h00007777);
    release_sel("rd07_fall");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
